// File: rtl/decoder6_64_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder6_64_pkg
//  Description : Shared types and constants for the decoder6_64 arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package decoder6_64_pkg;

    localparam int DEC_AW = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick, searching from last+1.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import decoder6_64_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_cand;
    logic          w_found;

    // One extra bit on the sum keeps last+k from wrapping before the mod step.
    always_comb begin
        win     = '0;
        win_idx = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_sum = {1'b0, last} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NREQ)) begin
                w_sum = w_sum - (IW+1)'(NREQ);
            end
            w_cand = w_sum[IW-1:0];
            if (!w_found && req[w_cand]) begin
                w_found      = 1'b1;
                win[w_cand]  = 1'b1;
                win_idx      = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoder6_64_arb.sv
`default_nettype none
// ============================================================================
//  Module      : decoder6_64_arb
//  Description : Round-robin sequencer sharing one decoder6_64 among requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder6_64_arb
    import decoder6_64_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DEC_AW-1:0]  addr,
    input  logic [NREQ*LEN_W-1:0]   len,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic                    dec_en,
    output logic [DEC_AW-1:0]       dec_A
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t        r_state;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_done;
    logic              r_en;
    logic [DEC_AW-1:0] r_a;
    logic [IW-1:0]     r_last;
    logic [LEN_W-1:0]  r_cnt;

    logic [DEC_AW-1:0] w_addr_arr [NREQ];
    logic [LEN_W-1:0]  w_len_arr  [NREQ];
    logic [NREQ-1:0]   w_win;
    logic [IW-1:0]     w_win_idx;
    logic [LEN_W-1:0]  w_len_sel;
    logic [LEN_W-1:0]  w_hold;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_addr_arr[gi] = addr[DEC_AW*gi +: DEC_AW];
        assign w_len_arr[gi]  = len[LEN_W*gi +: LEN_W];
    end

    rr_arbiter #(
        .NREQ    (NREQ),
        .IW      (IW)
    ) u_rr_arbiter (
        .req     (req),
        .last    (r_last),
        .win     (w_win),
        .win_idx (w_win_idx)
    );

    assign w_len_sel = w_len_arr[w_win_idx];
    assign w_hold    = (w_len_sel == '0) ? LEN_W'(1) : w_len_sel;

    // done is registered, so it is raised on the edge entering the last hold cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_en    <= 1'b0;
            r_a     <= '0;
            r_last  <= IW'(NREQ-1);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                GRANT: begin
                    if (r_cnt == LEN_W'(1)) begin
                        r_state <= GAP;
                        r_gnt   <= '0;
                        r_en    <= 1'b0;
                        r_done  <= '0;
                    end else begin
                        r_cnt  <= r_cnt - LEN_W'(1);
                        r_done <= (r_cnt == LEN_W'(2)) ? r_gnt : '0;
                    end
                end
                default: begin
                    if (|req) begin
                        r_state <= GRANT;
                        r_gnt   <= w_win;
                        r_en    <= 1'b1;
                        r_a     <= w_addr_arr[w_win_idx];
                        r_cnt   <= w_hold;
                        r_last  <= w_win_idx;
                        r_done  <= (w_hold == LEN_W'(1)) ? w_win : '0;
                    end else begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_en    <= 1'b0;
                        r_done  <= '0;
                    end
                end
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign done   = r_done;
    assign busy   = (r_state != IDLE);
    assign dec_en = r_en;
    assign dec_A  = r_a;

endmodule
`default_nettype wire

// File: tb/tb_decoder6_64_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder6_64_arb
//  Description : Self-checking bench for decoder6_64_arb against a cycle model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder6_64_arb;

    localparam int NREQ  = 4;
    localparam int LEN_W = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*6-1:0]      addr;
    logic [NREQ*LEN_W-1:0]  len;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic                   busy;
    logic                   dec_en;
    logic [5:0]             dec_A;

    logic [5:0]             ra [NREQ];
    logic [LEN_W-1:0]       rl [NREQ];

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: who owns the decoder, how many hold cycles remain
    int         m_owner;
    int         m_left;
    int         m_last;
    bit         m_gap;
    logic [5:0] m_a;

    decoder6_64_arb #(
        .NREQ   (NREQ),
        .LEN_W  (LEN_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .addr   (addr),
        .len    (len),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .dec_en (dec_en),
        .dec_A  (dec_A)
    );

    always #5 clk = ~clk;

    always_comb begin
        addr = '0;
        len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            addr[6*i +: 6]         = ra[i];
            len[LEN_W*i +: LEN_W]  = rl[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_owner = -1;
            m_left  = 0;
            m_gap   = 1'b0;
            m_last  = NREQ - 1;
            m_a     = '0;
        end else if (m_owner >= 0) begin
            if (m_left == 1) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_left = m_left - 1;
            end
        end else begin
            int w;
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (w < 0 && req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
            end
            m_gap = 1'b0;
            if (w >= 0) begin
                m_owner = w;
                m_left  = (rl[w] == '0) ? 1 : int'(rl[w]);
                m_a     = ra[w];
                m_last  = w;
            end
        end
    endtask

    task automatic tick();
        logic [63:0] exp_gnt;
        logic [63:0] y;
        model_step();
        @(negedge clk);
        exp_gnt = (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0;
        chk("gnt",    64'(gnt),    exp_gnt);
        chk("done",   64'(done),   (m_owner >= 0 && m_left == 1) ? exp_gnt : 64'd0);
        chk("busy",   64'(busy),   64'((m_owner >= 0) || m_gap));
        chk("dec_en", 64'(dec_en), 64'(m_owner >= 0));
        chk("dec_A",  64'(dec_A),  64'(m_a));
        y = dec_en ? (64'd1 << dec_A) : 64'd0;
        if (m_gap) chk("y_gap", y, 64'd0);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = '0;
            rl[i] = '0;
        end
        run(2);
        rst = 1'b0;
        run(10);

        // single request, 3-cycle hold
        ra[0] = 6'd5; rl[0] = 4'd3; req = 4'b0001;
        tick();
        req = 4'b0000;
        run(6);

        // everyone requesting, 1-cycle holds
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = 6'(10 + i);
            rl[i] = 4'd1;
        end
        req = 4'b1111;
        run(12);
        req = 4'b0000;
        run(3);

        // zero length treated as one, then a maximal hold with address change
        rl[0] = 4'd0; req = 4'b0001;
        tick();
        req = 4'b0000;
        run(3);
        ra[1] = 6'd33; rl[1] = 4'd15; req = 4'b0010;
        tick();
        req = 4'b0000;
        run(5);
        ra[1] = 6'd7; rl[1] = 4'd2;
        run(14);

        // reset in the second cycle of a 5-cycle grant
        rl[0] = 4'd5; ra[0] = 6'd21; req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ra[3] = 6'd63; rl[3] = 4'd2; req = 4'b1000;
        tick();
        req = 4'b0000;
        run(4);

        // requester 2 drops req during its own grant
        ra[2] = 6'd42; rl[2] = 4'd4; req = 4'b0100;
        tick();
        req = 4'b0000;
        run(7);

        // randomized traffic
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) req = NREQ'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                ra[i] = 6'($urandom);
                rl[i] = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom_range(0, 15))
                                                    : LEN_W'($urandom_range(0, 3));
            end
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        req = '0;
        run(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
